// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 encodings, FSM states, size helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lsu_pkg;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} lsu_state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == LSU_SB) || (f3 == LSU_SH) || (f3 == LSU_SW);
        return (f3 == LSU_LB) || (f3 == LSU_LH) || (f3 == LSU_LW) ||
               (f3 == LSU_LBU) || (f3 == LSU_LHU);
    endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Aligns merged two-word read data to the access offset and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none.
module lsu_load_format
    import lsu_pkg::*;
(
    input  logic [63:0] rdata_merged,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata_ext
);

    logic [31:0] aligned;

    always_comb begin
        aligned = 32'(rdata_merged >> {off, 3'b000});
        case (funct3)
            LSU_LB:  rdata_ext = {{24{aligned[7]}}, aligned[7:0]};
            LSU_LH:  rdata_ext = {{16{aligned[15]}}, aligned[15:0]};
            LSU_LW:  rdata_ext = aligned;
            LSU_LBU: rdata_ext = {24'b0, aligned[7:0]};
            LSU_LHU: rdata_ext = {16'b0, aligned[15:0]};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, word-boundary splits into two beats.
// Latency: accept->resp 2 cycles aligned, 3 split, 1 on error.
// Backpressure: req_ready only in IDLE; no stall on the memory side.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH       = 14,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_wstrb,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    lsu_state_t            state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            off_q, off_d;
    logic                  split_q, split_d;
    logic [ADDR_WIDTH-1:0] word0_q, word0_d;
    logic [31:0]           wdata_hi_q, wdata_hi_d;
    logic [3:0]            wstrb_hi_q, wstrb_hi_d;
    logic [31:0]           rdata_lo_q, rdata_lo_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [3:0]            mem_wstrb_q, mem_wstrb_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;

    logic [3:0]            req_mask;
    logic [31:0]           req_wd_masked;
    logic [3:0]            req_st_lo, req_st_hi;
    logic [31:0]           req_wd_lo, req_wd_hi;
    logic [ADDR_WIDTH-1:0] req_word0;
    logic                  req_split, req_err;
    logic [63:0]           rdata_merged;
    logic [31:0]           load_ext;

    always_comb begin
        req_mask      = size_mask(req_funct3[1:0]);
        req_wd_masked = req_wdata & {{8{req_mask[3]}}, {8{req_mask[2]}},
                                     {8{req_mask[1]}}, {8{req_mask[0]}}};
        {req_st_hi, req_st_lo} = {4'b0, req_mask} << req_addr[1:0];
        {req_wd_hi, req_wd_lo} = {32'b0, req_wd_masked} << {req_addr[1:0], 3'b000};
        req_word0 = req_addr[ADDR_WIDTH+1:2];
        // Any strobe spilling into the upper nibble means off + size > 4.
        req_split = |req_st_hi;
        req_err   = !funct3_legal(req_is_store, req_funct3) ||
                    (req_addr[31:ADDR_WIDTH+2] != '0) ||
                    (req_split && ((ALLOW_MISALIGNED == 0) || (&req_word0)));
    end

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        split_d      = split_q;
        word0_d      = word0_q;
        wdata_hi_d   = wdata_hi_q;
        wstrb_hi_d   = wstrb_hi_q;
        rdata_lo_d   = rdata_lo_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_wstrb_d  = '0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    off_d      = req_addr[1:0];
                    split_d    = req_split;
                    word0_d    = req_word0;
                    wdata_hi_d = req_wd_hi;
                    wstrb_hi_d = req_st_hi;
                    if (req_err) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = BEAT0;
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_is_store;
                        mem_addr_d  = req_word0;
                        mem_wdata_d = req_wd_lo;
                        mem_wstrb_d = req_st_lo;
                    end
                end
            end
            BEAT0: begin
                if (split_q) begin
                    state_d     = BEAT1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = is_store_q;
                    mem_addr_d  = word0_q + ADDR_WIDTH'(1);
                    mem_wdata_d = wdata_hi_q;
                    mem_wstrb_d = wstrb_hi_q;
                end else begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                end
            end
            BEAT1: begin
                if (!is_store_q)
                    rdata_lo_d = mem_rdata;
                state_d      = DONE;
                resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            split_q      <= 1'b0;
            word0_q      <= '0;
            wdata_hi_q   <= '0;
            wstrb_hi_q   <= '0;
            rdata_lo_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wstrb_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            split_q      <= split_d;
            word0_q      <= word0_d;
            wdata_hi_q   <= wdata_hi_d;
            wstrb_hi_q   <= wstrb_hi_d;
            rdata_lo_q   <= rdata_lo_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // The last beat's read data only arrives in DONE, so the load result is
    // formed from mem_rdata in that cycle rather than from a flop.
    assign rdata_merged = split_q ? {mem_rdata, rdata_lo_q} : {32'b0, mem_rdata};

    lsu_load_format u_fmt (
        .rdata_merged (rdata_merged),
        .off          (off_q),
        .funct3       (funct3_q),
        .rdata_ext    (load_ext)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = (resp_valid_q && !resp_err_q && !is_store_q) ? load_ext : '0;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
